uart_tx_ctrl: RTL and testbench

Transmit-side frame controller for the UART. It sits directly upstream of the TX PISO shift register and sequences it. On a transmit request it pulses the PISO load, then steps the PISO with shift. It computes the parity bit and muxes start, data, parity and stop bits onto the serial line. It runs on the baud-rate clock, so one clock cycle equals one bit time.

---
 rtl/uart_tx_ctrl_if.sv | 36 +++
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// ============================================================================
// Module      : uart_tx_ctrl_if
// Description : Handshake, PISO-control and serial-line bundle for uart_tx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] p_data_in;
    logic                  parity_en;
    logic                  parity_type;
    logic                  ser_in;
    logic                  load;
    logic                  shift;
    logic                  parity_bit;
    logic                  tx_out;
    logic                  busy;
    logic                  done;

    // Requester / PISO side
    modport master (
        output data_valid, p_data_in, parity_en, parity_type, ser_in,
        input  load, shift, parity_bit, tx_out, busy, done
    );

    // Frame controller side
    modport slave (
        input  data_valid, p_data_in, parity_en, parity_type, ser_in,
        output load, shift, parity_bit, tx_out, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit frame sequencer; drives PISO load/shift and muxes
//               start/data/parity/stop bits onto the line, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  wire logic         baud_rate_tx,
    input  wire logic         rst,
    uart_tx_ctrl_if.slave     bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH + STOP_BITS + 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    localparam logic [CNT_W-1:0] c_LAST_DATA = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_LAST_STOP = CNT_W'(STOP_BITS - 1);

    logic [2:0]       r_state_q,  w_state_d;
    logic [CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic             r_parity_q, w_parity_d;
    logic             r_par_en_q, w_par_en_d;
    logic             w_last_stop;
    logic             w_accept;

    assign w_last_stop = (r_state_q == c_STOP) && (r_cnt_q == c_LAST_STOP);
    // A new frame is only taken from idle or from the final stop bit.
    assign w_accept    = bus.data_valid && ((r_state_q == c_IDLE) || w_last_stop);

    always_ff @(posedge baud_rate_tx) begin
        if (rst) begin
            r_state_q  <= c_IDLE;
            r_cnt_q    <= '0;
            r_parity_q <= 1'b0;
            r_par_en_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_parity_q <= w_parity_d;
            r_par_en_q <= w_par_en_d;
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_parity_d = r_parity_q;
        w_par_en_d = r_par_en_q;
        case (r_state_q)
            c_IDLE: begin
                w_cnt_d = '0;
                if (w_accept) w_state_d = c_START;
            end
            c_START: begin
                w_cnt_d   = '0;
                w_state_d = c_DATA;
            end
            c_DATA: begin
                if (r_cnt_q == c_LAST_DATA) begin
                    w_cnt_d   = '0;
                    w_state_d = r_par_en_q ? c_PARITY : c_STOP;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            c_PARITY: begin
                w_cnt_d   = '0;
                w_state_d = c_STOP;
            end
            c_STOP: begin
                if (r_cnt_q == c_LAST_STOP) begin
                    w_cnt_d   = '0;
                    w_state_d = w_accept ? c_START : c_IDLE;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = c_IDLE;
            end
        endcase
        if (w_accept) begin
            w_parity_d = (^bus.p_data_in) ^ bus.parity_type;
            w_par_en_d = bus.parity_en;
        end
    end

    always_comb begin
        bus.tx_out     = 1'b1;
        bus.busy       = 1'b1;
        bus.load       = w_accept;
        bus.shift      = 1'b0;
        bus.done       = w_last_stop;
        bus.parity_bit = r_parity_q;
        case (r_state_q)
            c_IDLE:   bus.busy   = 1'b0;
            c_START:  bus.tx_out = 1'b0;
            c_DATA: begin
                bus.tx_out = bus.ser_in;
                // No shift after the last bit: the next load must see a quiet PISO.
                bus.shift  = (r_cnt_q < c_LAST_DATA);
            end
            c_PARITY: bus.tx_out = r_parity_q;
            c_STOP:   bus.tx_out = 1'b1;
            default:  bus.busy   = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Bench for uart_tx_ctrl; 1- and 2-stop-bit builds against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dv  = 1'b0;
    logic [DW-1:0] din = '0;
    logic          pe  = 1'b0;
    logic          pt  = 1'b0;
    logic [DW-1:0] piso_a, piso_b;

    int n_checks = 0;
    int n_err    = 0;

    // Frame-level reference: bit vector of the frame and the current position.
    logic [15:0] fr   [2];
    int          pos  [2] = '{-1, -1};
    int          len  [2] = '{0, 0};
    logic        epar [2] = '{1'b0, 1'b0};
    int          sb   [2] = '{1, 2};

    int          n_load_a, n_load_b, n_shift_a, n_busy_low_b;
    logic [15:0] hist_a;

    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) ifa ();
    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) ifb ();

    assign ifa.data_valid  = dv;
    assign ifa.p_data_in   = din;
    assign ifa.parity_en   = pe;
    assign ifa.parity_type = pt;
    assign ifa.ser_in      = piso_a[0];
    assign ifb.data_valid  = dv;
    assign ifb.p_data_in   = din;
    assign ifb.parity_en   = pe;
    assign ifb.parity_type = pt;
    assign ifb.ser_in      = piso_b[0];

    uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut_a (
        .baud_rate_tx (clk),
        .rst          (rst),
        .bus          (ifa)
    );

    uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut_b (
        .baud_rate_tx (clk),
        .rst          (rst),
        .bus          (ifb)
    );

    // Behavioural PISOs feeding ser_in
    always_ff @(posedge clk) begin
        if (ifa.load === 1'b1)       piso_a <= ifa.p_data_in;
        else if (ifa.shift === 1'b1) piso_a <= piso_a >> 1;
        if (ifb.load === 1'b1)       piso_b <= ifb.p_data_in;
        else if (ifb.shift === 1'b1) piso_b <= piso_b >> 1;
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_load(input int k);
        return !rst && dv && (pos[k] < 0 || pos[k] == len[k] - 1);
    endfunction

    function automatic logic exp_tx(input int k);
        return (pos[k] < 0) ? 1'b1 : fr[k][pos[k]];
    endfunction

    function automatic logic exp_done(input int k);
        return (pos[k] >= 0) && (pos[k] == len[k] - 1);
    endfunction

    function automatic logic exp_shift(input int k);
        return (pos[k] >= 1) && (pos[k] <= DW - 1);
    endfunction

    task automatic model_edge();
        logic par;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pos[k]  = -1;
                epar[k] = 1'b0;
            end else if (exp_load(k)) begin
                par   = (^din) ^ pt;
                fr[k] = '1;
                fr[k][0] = 1'b0;
                for (int i = 0; i < DW; i++) fr[k][1+i] = din[i];
                if (pe) fr[k][1+DW] = par;
                len[k]  = 1 + DW + (pe ? 1 : 0) + sb[k];
                pos[k]  = 0;
                epar[k] = par;
            end else if (pos[k] >= 0) begin
                pos[k]++;
                if (pos[k] >= len[k]) pos[k] = -1;
            end
        end
    endtask

    // One baud cycle: check load before the edge, advance model, check state after.
    task automatic step();
        #1;
        if (!rst) begin
            chk("load_a", ifa.load, exp_load(0));
            chk("load_b", ifb.load, exp_load(1));
        end
        if (ifa.load === 1'b1) n_load_a++;
        if (ifb.load === 1'b1) n_load_b++;
        @(posedge clk);
        #1;
        model_edge();
        chk("tx_a",    ifa.tx_out,     exp_tx(0));
        chk("busy_a",  ifa.busy,       pos[0] >= 0);
        chk("done_a",  ifa.done,       exp_done(0));
        chk("shift_a", ifa.shift,      exp_shift(0));
        chk("par_a",   ifa.parity_bit, epar[0]);
        chk("excl_a",  ifa.load & ifa.shift, 1'b0);
        chk("tx_b",    ifb.tx_out,     exp_tx(1));
        chk("busy_b",  ifb.busy,       pos[1] >= 0);
        chk("done_b",  ifb.done,       exp_done(1));
        chk("shift_b", ifb.shift,      exp_shift(1));
        chk("par_b",   ifb.parity_bit, epar[1]);
        hist_a = {hist_a[14:0], ifa.tx_out};
        if (ifa.shift === 1'b1) n_shift_a++;
        if (ifb.busy !== 1'b1) n_busy_low_b++;
    endtask

    initial begin
        // 1: reset then idle
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (5) step();

        // 2: 0x0F, even parity
        n_load_a = 0; n_shift_a = 0;
        din = 8'h0F; pe = 1'b1; pt = 1'b0; dv = 1'b1;
        step();
        dv = 1'b0;
        repeat (10) step();
        chk_int("frame_0f", int'(hist_a[10:0]), int'(11'b011_1100_0001));
        chk("par_0f", ifa.parity_bit, 1'b0);
        step();
        chk("idle_after_0f", ifa.tx_out, 1'b1);
        chk_int("loads_0f", n_load_a, 1);
        chk_int("shifts_0f", n_shift_a, 7);
        repeat (2) step();

        // 3: 0xA5, odd parity
        din = 8'hA5; pe = 1'b1; pt = 1'b1; dv = 1'b1;
        step();
        dv = 1'b0;
        repeat (10) step();
        chk_int("frame_a5", int'(hist_a[10:0]), int'(11'b010_1001_0111));
        chk("par_a5", ifa.parity_bit, 1'b1);
        repeat (3) step();

        // 4: back-to-back, no parity, data valid held
        n_load_b = 0; n_busy_low_b = 0;
        din = 8'h00; pe = 1'b0; pt = 1'b0; dv = 1'b1;
        repeat (33) step();
        chk_int("b2b_loads_b", n_load_b, 3);
        chk_int("b2b_busy_low_b", n_busy_low_b, 0);
        dv = 1'b0;
        repeat (12) step();

        // 5: reset during DATA cycle 3, then a clean frame
        din = 8'h3C; pe = 1'b1; pt = 1'b0; dv = 1'b1;
        step();
        dv = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_tx_a", ifa.tx_out, 1'b1);
        chk("rst_busy_a", ifa.busy, 1'b0);
        chk("rst_done_a", ifa.done, 1'b0);
        repeat (2) step();
        din = 8'h96; dv = 1'b1;
        step();
        dv = 1'b0;
        repeat (13) step();

        // 6: data_valid pulses mid-frame ignored, parity_en change ignored
        n_load_a = 0;
        din = 8'h5B; pe = 1'b1; pt = 1'b0; dv = 1'b1;
        step();
        dv = 1'b0;
        step();
        dv = 1'b1; pe = 1'b0; din = 8'hFF; pt = 1'b1;
        repeat (4) step();
        dv = 1'b0;
        repeat (3) step();
        dv = 1'b1;
        step();
        dv = 1'b0;
        step();
        chk_int("ignore_loads_a", n_load_a, 1);
        repeat (3) step();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            dv  = ($urandom % 3) == 0;
            din = DW'($urandom);
            pe  = $urandom % 2;
            pt  = $urandom % 2;
            rst = ($urandom % 97) == 0;
            step();
        end
        rst = 1'b0; dv = 1'b0;
        repeat (14) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
